// File: rtl/pulse_train_sequencer.sv
// rtl/pulse_train_sequencer.sv - Delay-then-N-pulses gate generator with abort.
// One shared down-counter times every phase; a pulse counter tracks pulses started.
module pulse_train_sequencer #(
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] gap,
    input  logic [NW-1:0] count,
    output logic          q,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] pulse_index
);

    typedef enum logic [1:0] {IDLE, DELAY, ON, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] wm1, wm1_n;
    logic [CW-1:0] gm1, gm1_n;
    logic [NW-1:0] total, total_n;
    logic [NW-1:0] pidx_n;
    logic          q_n, busy_n, done_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wm1         <= '0;
            gm1         <= '0;
            total       <= '0;
            pulse_index <= '0;
            q           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wm1         <= wm1_n;
            gm1         <= gm1_n;
            total       <= total_n;
            pulse_index <= pidx_n;
            q           <= q_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Phase lengths are stored as length-1 so a full-scale field never overflows.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wm1_n   = wm1;
        gm1_n   = gm1;
        total_n = total;
        pidx_n  = pulse_index;
        q_n     = q;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                q_n    = 1'b0;
                busy_n = 1'b0;
                if (start && !abort) begin
                    state_n = DELAY;
                    cnt_n   = delay;
                    wm1_n   = (width == '0) ? '0 : width - CW'(1);
                    gm1_n   = (gap == '0) ? '0 : gap - CW'(1);
                    total_n = count;
                    pidx_n  = '0;
                    busy_n  = 1'b1;
                end
            end
            DELAY: begin
                if (total == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (cnt == '0) begin
                    state_n = ON;
                    q_n     = 1'b1;
                    cnt_n   = wm1;
                    pidx_n  = pulse_index + NW'(1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ON: begin
                if (cnt == '0) begin
                    q_n = 1'b0;
                    if (pulse_index == total) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                        cnt_n   = gm1;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = ON;
                    q_n     = 1'b1;
                    cnt_n   = wm1;
                    pidx_n  = pulse_index + NW'(1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides every phase decision but leaves pulse_index visible.
        if (state != IDLE && abort) begin
            state_n = IDLE;
            q_n     = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            pidx_n  = pulse_index;
        end
    end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb/tb_pulse_train_sequencer.sv - Directed self-checking bench for pulse_train_sequencer.
module tb_pulse_train_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] delay = '0;
    logic [31:0] width = '0;
    logic [31:0] gap = '0;
    logic [15:0] count = '0;
    logic        q, busy, done;
    logic [15:0] pulse_index;

    int nvec = 0;
    int nerr = 0;

    pulse_train_sequencer #(.CW(32), .NW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .delay(delay), .width(width), .gap(gap), .count(count),
        .q(q), .busy(busy), .done(done), .pulse_index(pulse_index)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches a train at E0, scrambles the inputs afterwards, and checks every
    // edge up to and including the done edge. Returns in the done cycle.
    task automatic run_train(input string nm, input int d, input int w, input int g,
                             input int c, input int restart_k);
        int wl, gl, per, first, dk, ei;
        wl    = (w == 0) ? 1 : w;
        gl    = (g == 0) ? 1 : g;
        per   = wl + gl;
        first = d + 1;
        dk    = (c == 0) ? 1 : first + c * wl + (c - 1) * gl;
        delay = d; width = w; gap = g; count = 16'(c);
        start = 1'b1;
        step();
        start = 1'b0;
        delay = 0; width = 7; gap = 9; count = 1;
        chk($sformatf("%s E0 busy", nm), busy, 1);
        chk($sformatf("%s E0 q", nm), q, 0);
        chk($sformatf("%s E0 pidx", nm), pulse_index, 0);
        for (int k = 1; k <= dk; k++) begin
            start = (k == restart_k);
            step();
            start = 1'b0;
            ei = (k < first) ? 0 : ((k - first) / per + 1);
            if (ei > c) ei = c;
            chk($sformatf("%s E%0d q", nm, k), q,
                (c != 0 && k >= first && k < dk && ((k - first) % per) < wl) ? 1 : 0);
            chk($sformatf("%s E%0d busy", nm, k), busy, (k < dk) ? 1 : 0);
            chk($sformatf("%s E%0d done", nm, k), done, (k == dk) ? 1 : 0);
            chk($sformatf("%s E%0d pidx", nm, k), pulse_index, ei);
        end
    endtask

    initial begin
        #50;
        chk("reset q", q, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pidx", pulse_index, 0);
        #50;
        reset = 1'b0;
        step();

        // q at E11-13, E16-18, E21-23; done at E24.
        run_train("basic", 10, 3, 2, 3, -1);
        step();
        chk("basic idle busy", busy, 0);
        chk("basic idle done", done, 0);

        // Zero width/gap; the count=0 train starts in the done cycle.
        run_train("zero", 0, 0, 0, 2, -1);
        run_train("cnt0", 5, 4, 4, 0, -1);
        run_train("restart", 10, 3, 2, 3, 5);

        // Abort during second ON phase (E7-E9), sampled at E8.
        delay = 1; width = 3; gap = 2; count = 4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        chk("abort pre q", q, 1);
        chk("abort pre pidx", pulse_index, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort q", q, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort pidx", pulse_index, 2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort after %0d done", k), done, 0);
            chk($sformatf("abort after %0d q", k), q, 0);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        chk("prio busy", busy, 0);
        abort = 1'b0;
        start = 1'b0;
        step();
        chk("prio later busy", busy, 0);
        chk("prio later pidx", pulse_index, 2);

        // Async reset in the gap: pulse 1 ON E1-2, gap E3-7.
        delay = 0; width = 2; gap = 5; count = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        chk("rst pre busy", busy, 1);
        chk("rst pre pidx", pulse_index, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst async busy", busy, 0);
        chk("rst async q", q, 0);
        chk("rst async pidx", pulse_index, 0);
        step();
        step();
        chk("rst held done", done, 0);
        reset = 1'b0;
        step();
        chk("rst released busy", busy, 0);
        run_train("post_rst", 2, 1, 1, 2, -1);
        step();
        chk("final busy", busy, 0);
        chk("final done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
